// File: rtl/spi_regbank_arbiter.sv
// spi_regbank_arbiter
//
// Shares the single-port register bank of the SPI slave between the SPI
// protocol engine and a local host port. The SPI side issues fire-and-forget
// strobes into a one-entry buffer (sbuf). The host side uses valid/ready.
// A round-robin arbiter issues at most one bank access per cycle. Read data
// is returned to the issuing side one cycle after issue.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   spi_req/we/addr/wdata    single-cycle SPI request strobe and fields
//   spi_rdata, spi_rvalid    SPI read response (one-cycle pulse)
//   spi_ovf, spi_ovf_clr     sticky "SPI request dropped" flag and its clear
//   host_valid, host_ready   host handshake (ready = issued this cycle)
//   host_we/addr/wdata       host request fields
//   host_rdata, host_rvalid  host read response (one-cycle pulse)
//   bank_wr/addr/wdata       register bank access (zero when idle)
//   bank_rdata               register bank combinational read of bank_addr

module spi_regbank_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_rvalid,
  output logic              spi_ovf,
  input  logic              spi_ovf_clr,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              bank_wr,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);

  // Arbitration state: who received the most recent grant.
  typedef enum logic {
    LAST_SPI  = 1'b0,
    LAST_HOST = 1'b1
  } grant_e;

  grant_e last_grant_reg, last_grant_next;

  logic              sbuf_valid_reg;
  logic              sbuf_we_reg;
  logic [ADDR_W-1:0] sbuf_addr_reg;
  logic [DATA_W-1:0] sbuf_wdata_reg;

  logic              spi_ovf_reg;
  logic              spi_rvalid_reg;
  logic [DATA_W-1:0] spi_rdata_reg;
  logic              host_rvalid_reg;
  logic [DATA_W-1:0] host_rdata_reg;

  logic spi_cand, host_cand;
  logic grant_spi, grant_host;
  logic sbuf_load, ovf_set;

  // ---------------------------------------------------------------------------
  // Arbiter: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= LAST_HOST;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter: grant decision and next state
  // ---------------------------------------------------------------------------
  // The host candidate is gated with rst so that host_ready, which is
  // combinational from host_valid, stays low while the block is held in reset.
  always_comb begin
    spi_cand        = rst & sbuf_valid_reg;
    host_cand       = rst & host_valid;
    // On a tie the requester that was not granted last wins.
    grant_spi       = spi_cand & (~host_cand | (last_grant_reg == LAST_HOST));
    grant_host      = host_cand & ~grant_spi;
    last_grant_next = last_grant_reg;
    if (grant_spi) begin
      last_grant_next = LAST_SPI;
    end else if (grant_host) begin
      last_grant_next = LAST_HOST;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter: outputs (bank access mux and host handshake)
  // ---------------------------------------------------------------------------
  always_comb begin
    host_ready = grant_host;
    bank_wr    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (grant_spi) begin
      bank_wr    = sbuf_we_reg;
      bank_addr  = sbuf_addr_reg;
      bank_wdata = sbuf_wdata_reg;
    end else if (grant_host) begin
      bank_wr    = host_we;
      bank_addr  = host_addr;
      bank_wdata = host_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // SPI buffer and overflow flag
  // ---------------------------------------------------------------------------
  // A new strobe is accepted when the buffer is empty or is draining this very
  // cycle; otherwise it is lost and the sticky overflow flag records it.
  always_comb begin
    sbuf_load = spi_req & (~sbuf_valid_reg | grant_spi);
    ovf_set   = spi_req & sbuf_valid_reg & ~grant_spi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbuf_valid_reg <= 1'b0;
      sbuf_we_reg    <= 1'b0;
      sbuf_addr_reg  <= '0;
      sbuf_wdata_reg <= '0;
    end else if (sbuf_load) begin
      sbuf_valid_reg <= 1'b1;
      sbuf_we_reg    <= spi_we;
      sbuf_addr_reg  <= spi_addr;
      sbuf_wdata_reg <= spi_wdata;
    end else if (grant_spi) begin
      sbuf_valid_reg <= 1'b0;
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_ovf_reg <= 1'b0;
    end else begin
      spi_ovf_reg <= ovf_set | (spi_ovf_reg & ~spi_ovf_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Read responses
  // ---------------------------------------------------------------------------
  // rdata only updates on a read issue, so it holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_rvalid_reg  <= 1'b0;
      spi_rdata_reg   <= '0;
      host_rvalid_reg <= 1'b0;
      host_rdata_reg  <= '0;
    end else begin
      spi_rvalid_reg  <= grant_spi & ~sbuf_we_reg;
      host_rvalid_reg <= grant_host & ~host_we;
      if (grant_spi && !sbuf_we_reg) begin
        spi_rdata_reg <= bank_rdata;
      end
      if (grant_host && !host_we) begin
        host_rdata_reg <= bank_rdata;
      end
    end
  end

  assign spi_ovf     = spi_ovf_reg;
  assign spi_rvalid  = spi_rvalid_reg;
  assign spi_rdata   = spi_rdata_reg;
  assign host_rvalid = host_rvalid_reg;
  assign host_rdata  = host_rdata_reg;

endmodule

// File: doc/spi_regbank_arbiter.md
# spi_regbank_arbiter

Shares the single-port register bank of the SPI slave between two requesters: the SPI protocol engine (fire-and-forget strobes) and a local host port (valid/ready).
- Buffers one SPI request, so SPI traffic is never stalled.
- Arbitrates round-robin, with at most one bank access per cycle.
- Returns read data one cycle after issue.
- Sits between the SPI protocol engine / host logic and the register bank inside the SPI slave.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 4, register address width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- spi_req  in  1  single-cycle request strobe from SPI protocol engine
- spi_we  in  1  1 = write, 0 = read (qualified by spi_req)
- spi_addr  in  ADDR_W  register address (qualified by spi_req)
- spi_wdata  in  DATA_W  write data (qualified by spi_req)
- spi_rdata  out  DATA_W  read data, valid with spi_rvalid
- spi_rvalid  out  1  one-cycle read-response pulse
- spi_ovf  out  1  sticky: SPI request dropped
- spi_ovf_clr  in  1  clears spi_ovf
- host_valid  in  1  host request pending
- host_ready  out  1  host request issued this cycle
- host_we, host_addr, host_wdata  in  1/ADDR_W/DATA_W  host request fields, held stable while host_valid=1 and host_ready=0
- host_rdata  out  DATA_W  read data, valid with host_rvalid
- host_rvalid  out  1  one-cycle read-response pulse
- bank_wr  out  1  register bank write enable
- bank_addr  out  ADDR_W  register bank address
- bank_wdata  out  DATA_W  register bank write data
- bank_rdata  in  DATA_W  register bank combinational read of bank_addr

## Operation
SPI buffer (sbuf):
- One entry: valid, we, addr, wdata.
- spi_req=1 loads sbuf at the clock edge when sbuf is empty, or when sbuf is being issued that same cycle (simultaneous drain and refill).
- spi_req=1 while sbuf is valid and not issued: the request is dropped, sbuf is unchanged, and spi_ovf is set.

spi_ovf:
- spi_ovf_clr clears it.
- If a set and a clear occur in the same cycle, the set wins.

Arbitration, evaluated every cycle:
- Candidates are sbuf.valid and host_valid.
- Only one candidate: that candidate is granted.
- Both candidates: grant goes to the requester not granted last (round-robin).
- last_grant is updated on every grant.
- Reset value of last_grant is HOST, so SPI wins the first tie.

Issue:
- The granted request drives bank_addr and bank_wdata.
- bank_wr equals the request's we bit.
- host_ready=1 only in a cycle where the host is granted; host_ready is combinational from host_valid and the arbitration state.
- Granting SPI clears sbuf.valid at the edge, unless the same-cycle refill applies.
- No grant: bank_wr=0, bank_addr=0, bank_wdata=0.

Read response:
- On a read issue, bank_rdata is registered into the granted side's rdata register.
- That side's rvalid pulses for exactly one cycle on the next cycle.
- Writes produce no response.
- rdata holds its last value between responses.

Reads and writes:
- Back-to-back issues, one per cycle, are supported.
- A read in cycle N+1 after a write to the same address in cycle N returns the new data.

## Timing
Reset state, while rst=0 and immediately after release:
- sbuf empty; last_grant=HOST; spi_ovf=0.
- spi_rvalid=0, host_rvalid=0.
- spi_rdata=0, host_rdata=0.
- bank_wr=0, host_ready=0.

Latency:
- SPI: spi_req sampled at edge N → earliest issue in cycle N+1 → spi_rvalid in cycle N+2.
- Host: host_valid && host_ready in cycle M → host_rvalid in cycle M+1.
- Worst-case SPI issue delay with host saturating the bank: 2 cycles after sbuf loads.
- Worst-case host wait with SPI saturating the bank: 1 cycle.

Reset mid-operation:
- Asserting rst drops any buffered or in-flight request.
- No rvalid is generated for dropped requests.

Throughput: one bank access per clock cycle.

## Test plan
- Reset: hold rst=0 with host_valid=1 and spi_req=1 → bank_wr=0, host_ready=0, and all rvalid/ovf outputs stay 0.
- SPI write then read: write 0xA5A5_0001 to address 3 at cycle 0, then read address 3 at cycle 2 → bank_wr pulses in cycle 1; spi_rvalid=1 with spi_rdata=0xA5A5_0001 in cycle 4.
- Contention: host_valid held continuously, host reading address 5; SPI reads address 6 strobed every 2 cycles → grants alternate SPI/HOST on ties, no spi_ovf, and each rdata matches its own address.
- Overflow: host_valid held; spi_req strobed in two consecutive cycles while sbuf is blocked by a host grant → second request dropped, spi_ovf=1; spi_ovf_clr pulse → spi_ovf=0.
- Drain and refill: spi_req in the cycle sbuf issues → new request captured, no overflow, two SPI issues in consecutive cycles.
- Reset mid-read: host read issued in cycle M, rst asserted before edge M+1 → host_rvalid stays 0 and host_rdata=0.
